serial_link_channel_striper: RTL
================================

Name: serial_link_channel_striper

Overview:
Transmit-side channel-bonding stage for the multi-channel serial link. It takes wide flits and splits each one into ChanWidth slices. The slices are striped round-robin across the enabled physical channels, with per-channel credit-based flow control. Channels can be masked at runtime (faulty or power-gated), and mask changes take effect only on flit boundaries. It sits between the AXI-to-flit packetiser and the per-channel DDR PHY serialisers, in the fast serial-link clock domain.

Parameters:
NumChannels, 8, number of physical channels
ChanWidth, 16, slice width per channel beat (NumLanes*2 for DDR)
FlitWidth, 64, input flit width; must be an integer multiple of ChanWidth (elaboration assertion)
MaxCredits, 8, per-channel receiver buffer depth in slices
NumSlices, FlitWidth/ChanWidth, derived; TagW = max(1,$clog2(NumSlices)); CntW = $clog2(MaxCredits+1)

Ports:
clk_i  in  1  link clock
rst_ni  in  1  asynchronous active-low reset
flit_i  in  FlitWidth  flit payload
flit_valid_i  in  1  flit valid
flit_ready_o  out  1  flit accepted when valid&ready
cfg_ch_en_i  in  NumChannels  requested channel enable mask
cfg_update_i  in  1  one-cycle pulse: latch cfg_ch_en_i as pending mask
ch_valid_o  out  NumChannels  slice valid per channel (registered)
ch_data_o  out  NumChannels*ChanWidth  slice payload per channel (registered)
ch_tag_o  out  NumChannels*TagW  slice index within flit (registered)
credit_ret_i  in  NumChannels  one-cycle credit return per channel
credits_o  out  NumChannels*CntW  current credit count per channel
active_mask_o  out  NumChannels  mask currently in use
busy_o  out  1  high in SEND
credit_err_o  out  1  sticky: credit returned while counter already at MaxCredits

Behaviour:
- Reset values: state IDLE, active_mask_o all-ones, pending flag 0, rr pointer 0, credits_o = MaxCredits each, ch_valid_o 0, ch_data_o 0, ch_tag_o 0, credit_err_o 0, busy_o 0. Reset is asynchronous: assertion mid-flit aborts it; the partially sent flit is lost and no further slices are issued.
- flit_ready_o = (state==IDLE) & |active_mask_o & ~pending. With an all-zero mask, input stalls indefinitely.
- IDLE: if pending, then active_mask_o <= pending mask, pending cleared, no accept that cycle. Else on valid&ready: flit registered, slice_idx <= 0, state SEND.
- SEND, each cycle: eligible[c] = active_mask_o[c] & (credits[c]>0). Starting at rr pointer, walk channels cyclically. Assign consecutive slices (slice_idx, slice_idx+1, ...) to eligible channels in walk order, up to the remaining slice count. Slice k = flit[k*ChanWidth +: ChanWidth], with tag k.
- Assigned channels: ch_valid_o=1, data and tag set at the next edge (1-cycle registered latency). Unassigned channels: ch_valid_o=0, and data/tag hold their previous values.
- rr pointer <= channel after the last assigned channel, mod NumChannels. It is unchanged if nothing is assigned.
- If no channel is eligible, stay in SEND with no output. This is not an error.
- When the last slice is assigned: state <= IDLE. Minimum flit spacing is 2 cycles (accept, SEND).
- Credits per channel:
  - Decrement when a slice is assigned.
  - Increment on credit_ret_i.
  - Both in the same cycle: unchanged.
  - Return at MaxCredits with no send: saturate and set credit_err_o (sticky until reset).
  - Masked channels still accept credit returns.
- cfg_update_i in any state: pending mask <= cfg_ch_en_i. A second pulse before application overwrites it. Application happens only in IDLE, so a mask change never splits a flit across two masks.

Test Plan:
1. Reset, all 8 channels enabled, send flit 0x4444_3333_2222_1111 -> the cycle after SEND: ch_valid_o=0x0F, ch0..3 data 0x1111/0x2222/0x3333/0x4444, tags 0..3; rr=4; next flit lands on ch4..7 (ch_valid_o=0xF0).
2. Only ch0 enabled (update pulse, then IDLE apply), no credit returns -> 2 flits use all 8 credits; 3rd flit stalls in SEND with busy_o=1. Pulse credit_ret_i[0] -> exactly one slice is issued per return.
3. cfg_update_i with mask 0x03 while in SEND -> current flit completes on the old mask; active_mask_o=0x03 one IDLE cycle later; flit_ready_o is low during that cycle.
4. ch2 at 7 credits receives a slice assignment and credit_ret_i[2] in the same cycle -> credits stay 7. Return to ch5 at 8 credits -> stays 8, credit_err_o=1 and remains 1.
5. Mask 0x00 applied -> flit_ready_o stays 0 for 100 cycles, no ch_valid_o.
6. Assert rst_ni mid-SEND -> all outputs immediately return to reset values; after release, credits=8 and a new flit starts at ch0.

Source files
------------

// File: rtl/serial_link_channel_striper.sv
// Transmit-side channel bonding: cuts wide flits into slices and stripes
// them round-robin over the enabled, credited physical channels.
module serial_link_channel_striper #(
  parameter int unsigned NumChannels = 8,
  parameter int unsigned ChanWidth   = 16,
  parameter int unsigned FlitWidth   = 64,
  parameter int unsigned MaxCredits  = 8,
  localparam int unsigned NumSlices = FlitWidth / ChanWidth,
  localparam int unsigned TagW =
    (NumSlices > 1) ? $clog2(NumSlices) : 1,
  localparam int unsigned CntW = $clog2(MaxCredits + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [FlitWidth-1:0]           flit_i,
  input  logic                           flit_valid_i,
  output logic                           flit_ready_o,
  input  logic [NumChannels-1:0]         cfg_ch_en_i,
  input  logic                           cfg_update_i,
  output logic [NumChannels-1:0]         ch_valid_o,
  output logic [NumChannels*ChanWidth-1:0] ch_data_o,
  output logic [NumChannels*TagW-1:0]    ch_tag_o,
  input  logic [NumChannels-1:0]         credit_ret_i,
  output logic [NumChannels*CntW-1:0]    credits_o,
  output logic [NumChannels-1:0]         active_mask_o,
  output logic                           busy_o,
  output logic                           credit_err_o
);

  localparam int unsigned PtrW =
    (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned IdxW = $clog2(NumSlices + 1);

  if (FlitWidth % ChanWidth != 0) begin : g_bad_width
    $error("FlitWidth must be a multiple of ChanWidth");
  end

  typedef enum logic {Idle, Send} state_e;

  state_e                               state_q, state_d;
  logic [FlitWidth-1:0]                 flit_q, flit_d;
  logic [IdxW-1:0]                      idx_q, idx_d;
  logic [PtrW-1:0]                      rr_q, rr_d;
  logic [NumChannels-1:0]               mask_q, mask_d;
  logic [NumChannels-1:0]               pmask_q, pmask_d;
  logic                                 pend_q, pend_d;
  logic [NumChannels-1:0][CntW-1:0]     cred_q, cred_d;
  logic [NumChannels-1:0]               valid_q, valid_d;
  logic [NumChannels-1:0][ChanWidth-1:0] data_q, data_d;
  logic [NumChannels-1:0][TagW-1:0]     tag_q, tag_d;
  logic                                 err_q, err_d;

  logic [NumSlices-1:0][ChanWidth-1:0]  slices;
  logic [NumChannels-1:0]               elig;
  logic [NumChannels-1:0]               asg;
  logic [NumChannels-1:0][TagW-1:0]     slot;
  logic [IdxW-1:0]                      n_asg;
  logic [PtrW-1:0]                      last_ch;

  assign slices       = flit_q;
  assign flit_ready_o = (state_q == Idle) & (|mask_q) & ~pend_q;

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      elig[c] = mask_q[c] & (cred_q[c] != '0);
    end
  end

  // Walk from the rr pointer, handing consecutive slices to eligible channels.
  always_comb begin
    int unsigned     cnt;
    logic [PtrW-1:0] c;
    asg     = '0;
    slot    = '0;
    cnt     = 0;
    c       = '0;
    last_ch = rr_q;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      c = PtrW'((32'(rr_q) + i) % NumChannels);
      if (state_q == Send && elig[c] &&
          (32'(idx_q) + cnt < NumSlices)) begin
        asg[c]  = 1'b1;
        slot[c] = TagW'(32'(idx_q) + cnt);
        cnt     = cnt + 1;
        last_ch = c;
      end
    end
    n_asg = IdxW'(cnt);
  end

  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    pmask_d = pmask_q;
    cred_d  = cred_q;
    valid_d = asg;
    data_d  = data_q;
    tag_d   = tag_q;
    err_d   = err_q;

    unique case (state_q)
      Idle: begin
        if (pend_q) begin
          mask_d = pmask_q;
          pend_d = 1'b0;
        end else if (flit_valid_i && flit_ready_o) begin
          flit_d  = flit_i;
          idx_d   = '0;
          state_d = Send;
        end
      end
      Send: begin
        if (n_asg != '0) begin
          rr_d  = (last_ch == PtrW'(NumChannels - 1)) ?
                  '0 : last_ch + PtrW'(1);
          idx_d = idx_q + n_asg;
          if (32'(idx_q) + 32'(n_asg) == NumSlices) begin
            state_d = Idle;
          end
        end
      end
      default: state_d = Idle;
    endcase

    // A later pulse wins, including one landing on the apply cycle.
    if (cfg_update_i) begin
      pend_d  = 1'b1;
      pmask_d = cfg_ch_en_i;
    end

    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (asg[c]) begin
        data_d[c] = slices[slot[c]];
        tag_d[c]  = slot[c];
      end
      unique case ({asg[c], credit_ret_i[c]})
        2'b10: cred_d[c] = cred_q[c] - CntW'(1);
        2'b01: begin
          if (cred_q[c] == CntW'(MaxCredits)) begin
            err_d = 1'b1;
          end else begin
            cred_d[c] = cred_q[c] + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      flit_q  <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      mask_q  <= '1;
      pend_q  <= 1'b0;
      pmask_q <= '0;
      cred_q  <= {NumChannels{CntW'(MaxCredits)}};
      valid_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      pmask_q <= pmask_d;
      cred_q  <= cred_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign ch_valid_o    = valid_q;
  assign ch_data_o     = data_q;
  assign ch_tag_o      = tag_q;
  assign credits_o     = cred_q;
  assign active_mask_o = mask_q;
  assign busy_o        = (state_q == Send);
  assign credit_err_o  = err_q;

endmodule
